// File: rtl/cpu_clk_pkg.sv
// Shared encodings for the CPU clock-enable controller: FSM states and
// the meaning of the two mode switches.
package cpu_clk_pkg;

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    TRAP = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    MODE_HALT = 2'd0,
    MODE_RUN  = 2'd1,
    MODE_STEP = 2'd2,
    MODE_FAST = 2'd3
  } mode_t;

  function automatic logic is_run_mode(input mode_t m);
    return (m == MODE_RUN) || (m == MODE_FAST);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronizes and debounces an active-low pushbutton; emits a one-cycle
// press pulse when the accepted level falls from high to low.
module key_debounce #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
  input  logic inclk0,
  input  logic rst_n,
  input  logic key_raw,
  output logic key_level,
  output logic press
);

  logic        key_s1_r;
  logic        key_s2_r;
  logic        level_r;
  logic        press_r;
  logic [19:0] cnt_r;

  // Two-stage synchronizer; an idle key reads high.
  always_ff @(posedge inclk0 or negedge rst_n) begin
    if (!rst_n) begin
      key_s1_r <= 1'b1;
      key_s2_r <= 1'b1;
    end else begin
      key_s1_r <= key_raw;
      key_s2_r <= key_s1_r;
    end
  end

  // Accept a new level after DEBOUNCE_CYCLES+1 consecutive differing samples;
  // any sample matching the current level restarts the count.
  always_ff @(posedge inclk0 or negedge rst_n) begin
    if (!rst_n) begin
      level_r <= 1'b1;
      press_r <= 1'b0;
      cnt_r   <= 20'd0;
    end else if (key_s2_r == level_r) begin
      press_r <= 1'b0;
      cnt_r   <= 20'd0;
    end else if (cnt_r == DEBOUNCE_CYCLES) begin
      level_r <= key_s2_r;
      press_r <= ~key_s2_r;
      cnt_r   <= 20'd0;
    end else begin
      press_r <= 1'b0;
      cnt_r   <= cnt_r + 20'd1;
    end
  end

  assign key_level = level_r;
  assign press     = press_r;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Run/halt/single-step controller producing a one-cycle CPU clock enable
// from the board clock, with programmable run rate and halt-to-trap.
module cpu_clk_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int unsigned          BIT_WIDTH       = 32,
  parameter logic [BIT_WIDTH-1:0] DEFAULT_TMIN    = 32'd2500000,
  parameter logic [19:0]          DEBOUNCE_CYCLES = 20'd500000
) (
  input  logic                 inclk0,
  input  logic                 rst_n,
  input  logic [1:0]           mode_sel,
  input  logic                 step_key,
  input  logic                 tmin_wr,
  input  logic [BIT_WIDTH-1:0] tmin_data,
  input  logic                 halt_req,
  output logic                 cpu_en,
  output logic                 c0,
  output logic [1:0]           state,
  output logic [BIT_WIDTH-1:0] cycle_cnt
);

  logic [1:0]           mode_s1_r;
  logic [1:0]           mode_s2_r;
  mode_t                mode_s;
  state_t               state_r;
  logic [BIT_WIDTH-1:0] cnt_r;
  logic [BIT_WIDTH-1:0] tmin_r;
  logic                 cpu_en_r;
  logic                 c0_r;
  logic [BIT_WIDTH-1:0] cycle_cnt_r;
  logic                 fire_s;
  logic                 press_s;
  logic                 key_level_s;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_key (
    .inclk0   (inclk0),
    .rst_n    (rst_n),
    .key_raw  (step_key),
    .key_level(key_level_s),
    .press    (press_s)
  );

  // Mode switch synchronizer.
  always_ff @(posedge inclk0 or negedge rst_n) begin
    if (!rst_n) begin
      mode_s1_r <= 2'b00;
      mode_s2_r <= 2'b00;
    end else begin
      mode_s1_r <= mode_sel;
      mode_s2_r <= mode_s1_r;
    end
  end

  assign mode_s = mode_t'(mode_s2_r);

  // Period register; a write never disturbs the count already in flight.
  always_ff @(posedge inclk0 or negedge rst_n) begin
    if (!rst_n) begin
      tmin_r <= DEFAULT_TMIN;
    end else if (tmin_wr) begin
      tmin_r <= tmin_data;
    end else begin
      tmin_r <= tmin_r;
    end
  end

  // Decide whether the next cycle carries a CPU enable; halt_req vetoes it.
  always_comb begin
    fire_s = 1'b0;
    if (halt_req) begin
      fire_s = 1'b0;
    end else if (state_r == RUN) begin
      case (mode_s)
        MODE_RUN:  fire_s = (cnt_r == {BIT_WIDTH{1'b0}});
        MODE_FAST: fire_s = 1'b1;
        default:   fire_s = 1'b0;
      endcase
    end else if ((state_r == STEP) && (mode_s == MODE_STEP)) begin
      fire_s = press_s & ~key_level_s;
    end else begin
      fire_s = 1'b0;
    end
  end

  // Controller FSM and divider counter.
  always_ff @(posedge inclk0 or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= HALT;
      cnt_r   <= DEFAULT_TMIN;
    end else begin
      case (state_r)
        HALT: begin
          if (is_run_mode(mode_s)) begin
            state_r <= RUN;
            cnt_r   <= tmin_r;
          end else if (mode_s == MODE_STEP) begin
            state_r <= STEP;
          end else begin
            state_r <= HALT;
          end
        end
        RUN: begin
          if (halt_req) begin
            state_r <= TRAP;
          end else begin
            case (mode_s)
              MODE_RUN:  cnt_r   <= (cnt_r == {BIT_WIDTH{1'b0}}) ? tmin_r : cnt_r - BIT_WIDTH'(1'b1);
              MODE_FAST: cnt_r   <= tmin_r;
              MODE_STEP: state_r <= STEP;
              default:   state_r <= HALT;
            endcase
          end
        end
        STEP: begin
          if (halt_req) begin
            state_r <= TRAP;
          end else if (mode_s == MODE_HALT) begin
            state_r <= HALT;
          end else if (is_run_mode(mode_s)) begin
            state_r <= RUN;
            cnt_r   <= tmin_r;
          end else begin
            state_r <= STEP;
          end
        end
        TRAP: begin
          state_r <= (mode_s == MODE_HALT) ? HALT : TRAP;
        end
        default: begin
          state_r <= HALT;
        end
      endcase
    end
  end

  // Registered enable, LED toggle and issued-pulse counter.
  always_ff @(posedge inclk0 or negedge rst_n) begin
    if (!rst_n) begin
      cpu_en_r    <= 1'b0;
      c0_r        <= 1'b0;
      cycle_cnt_r <= {BIT_WIDTH{1'b0}};
    end else begin
      cpu_en_r <= fire_s;
      if (fire_s) begin
        c0_r        <= ~c0_r;
        cycle_cnt_r <= cycle_cnt_r + BIT_WIDTH'(1'b1);
      end else begin
        c0_r        <= c0_r;
        cycle_cnt_r <= cycle_cnt_r;
      end
    end
  end

  assign cpu_en    = cpu_en_r;
  assign c0        = c0_r;
  assign state     = state_r;
  assign cycle_cnt = cycle_cnt_r;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Bench for cpu_clk_ctrl: directed scenarios plus randomized stimulus, all
// compared every cycle against an event-level reference model.
module tb_cpu_clk_ctrl;

  localparam logic [31:0] DEF_TMIN = 32'd40;
  localparam int          DEB      = 4;

  logic        inclk0    = 1'b0;
  logic        rst_n     = 1'b0;
  logic [1:0]  mode_sel  = 2'b00;
  logic        step_key  = 1'b1;
  logic        tmin_wr   = 1'b0;
  logic [31:0] tmin_data = 32'd0;
  logic        halt_req  = 1'b0;
  logic        cpu_en;
  logic        c0;
  logic [1:0]  state;
  logic [31:0] cycle_cnt;

  always #5 inclk0 = ~inclk0;

  cpu_clk_ctrl #(
    .BIT_WIDTH(32),
    .DEFAULT_TMIN(DEF_TMIN),
    .DEBOUNCE_CYCLES(20'd4)
  ) dut (
    .inclk0(inclk0), .rst_n(rst_n), .mode_sel(mode_sel), .step_key(step_key),
    .tmin_wr(tmin_wr), .tmin_data(tmin_data), .halt_req(halt_req),
    .cpu_en(cpu_en), .c0(c0), .state(state), .cycle_cnt(cycle_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Reference model: delayed switch/key views, consecutive-sample debounce,
  // and run rate expressed as cycles elapsed since the last reload.
  logic [1:0]  m_md1, m_md2, m_state;
  logic        m_kd1, m_kd2, m_lvl, m_press, m_en, m_c0;
  int          m_run;
  longint      m_since, m_period;
  logic [31:0] m_tmin, m_cnt;

  task automatic model_reset();
    m_md1 = 2'd0; m_md2 = 2'd0; m_state = 2'd0;
    m_kd1 = 1'b1; m_kd2 = 1'b1; m_lvl = 1'b1; m_press = 1'b0;
    m_en = 1'b0; m_c0 = 1'b0; m_run = 0; m_since = 0; m_period = 0;
    m_tmin = DEF_TMIN; m_cnt = 32'd0;
  endtask

  task automatic model_step();
    logic [1:0] ms;
    logic       ks, pr, fire;
    ms = m_md2; ks = m_kd2; pr = m_press; fire = 1'b0;
    m_md2 = m_md1; m_md1 = mode_sel;
    m_kd2 = m_kd1; m_kd1 = step_key;
    m_press = 1'b0;
    if (ks != m_lvl) begin
      m_run++;
      if (m_run == DEB + 1) begin
        m_lvl = ks; m_press = ~ks; m_run = 0;
      end
    end else m_run = 0;
    case (m_state)
      2'd0: if (ms == 2'd1 || ms == 2'd3) begin
              m_state = 2'd1; m_since = 0; m_period = m_tmin;
            end else if (ms == 2'd2) m_state = 2'd2;
      2'd1: if (halt_req) m_state = 2'd3;
            else if (ms == 2'd0) m_state = 2'd0;
            else if (ms == 2'd2) m_state = 2'd2;
            else if (ms == 2'd3) begin fire = 1'b1; m_since = 0; m_period = m_tmin; end
            else begin
              m_since++;
              if (m_since == m_period + 1) begin fire = 1'b1; m_since = 0; m_period = m_tmin; end
            end
      2'd2: if (halt_req) m_state = 2'd3;
            else if (ms == 2'd0) m_state = 2'd0;
            else if (ms == 2'd2) fire = pr;
            else begin m_state = 2'd1; m_since = 0; m_period = m_tmin; end
      default: if (ms == 2'd0) m_state = 2'd0;
    endcase
    if (tmin_wr) m_tmin = tmin_data;
    m_en = fire;
    if (fire) begin m_c0 = ~m_c0; m_cnt++; end
  endtask

  task automatic tick();
    @(posedge inclk0);
    if (rst_n) model_step();
    @(negedge inclk0);
    check_val("cpu_en", {63'd0, cpu_en}, {63'd0, m_en});
    check_val("c0", {63'd0, c0}, {63'd0, m_c0});
    check_val("state", {62'd0, state}, {62'd0, m_state});
    check_val("cycle_cnt", {32'd0, cycle_cnt}, {32'd0, m_cnt});
  endtask

  task automatic write_tmin(input logic [31:0] v);
    tmin_data = v; tmin_wr = 1'b1;
    tick();
    tmin_wr = 1'b0;
  endtask

  initial begin
    logic [31:0] base;
    logic        key_tgt;
    model_reset();

    // Reset held with run mode selected.
    rst_n = 1'b0; mode_sel = 2'b01;
    repeat (3) tick();
    check_val("rst_cpu_en", {63'd0, cpu_en}, 64'd0);
    check_val("rst_c0", {63'd0, c0}, 64'd0);
    check_val("rst_state", {62'd0, state}, 64'd0);
    check_val("rst_cycle_cnt", {32'd0, cycle_cnt}, 64'd0);
    mode_sel = 2'b00; rst_n = 1'b1;
    repeat (100) tick();
    check_val("halt_idle", {32'd0, cycle_cnt}, 64'd0);

    // Run rate, tmin = 3.
    write_tmin(32'd3);
    mode_sel = 2'b01;
    for (int i = 0; i < 200 && m_cnt < 32'd10; i++) tick();
    check_val("run10_cnt", {32'd0, cycle_cnt}, 64'd10);
    check_val("run10_c0", {63'd0, c0}, 64'd0);

    // Single step: glitch, then a clean press with exact pulse timing.
    mode_sel = 2'b10;
    repeat (8) tick();
    base = m_cnt;
    step_key = 1'b0; tick();
    step_key = 1'b1; tick();
    step_key = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check_val("step_edge", {63'd0, cpu_en}, (k == 8) ? 64'd1 : 64'd0);
    end
    step_key = 1'b1; repeat (12) tick();
    check_val("step_one", {32'd0, cycle_cnt}, {32'd0, base + 32'd1});
    step_key = 1'b0; repeat (10) tick();
    step_key = 1'b1; repeat (12) tick();
    check_val("step_two", {32'd0, cycle_cnt}, {32'd0, base + 32'd2});

    // Presses outside STEP are discarded, not queued.
    mode_sel = 2'b00; repeat (6) tick();
    base = m_cnt;
    step_key = 1'b0; repeat (10) tick();
    step_key = 1'b1; repeat (12) tick();
    check_val("halt_press", {32'd0, cycle_cnt}, {32'd0, base});
    mode_sel = 2'b10; repeat (10) tick();
    check_val("no_queue", {32'd0, cycle_cnt}, {32'd0, base});

    // Halt request from RUN with tmin = 0.
    write_tmin(32'd0);
    mode_sel = 2'b01; repeat (10) tick();
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    check_val("halt_en", {63'd0, cpu_en}, 64'd0);
    check_val("halt_trap", {62'd0, state}, 64'd3);
    repeat (50) tick();
    check_val("trap_hold", {62'd0, state}, 64'd3);
    mode_sel = 2'b00; repeat (4) tick();
    check_val("trap_exit", {62'd0, state}, 64'd0);

    // Period change mid-count: tmin 7, rewritten to 1 three cycles in.
    write_tmin(32'd7);
    mode_sel = 2'b01;
    for (int i = 0; i < 10 && m_state != 2'd1; i++) tick();
    check_val("pc_entry", {62'd0, state}, 64'd1);
    repeat (2) tick();
    write_tmin(32'd1);
    for (int k = 4; k <= 20; k++) begin
      tick();
      check_val("pc_edge", {63'd0, cpu_en}, (k >= 8 && ((k - 8) % 2) == 0) ? 64'd1 : 64'd0);
    end

    // Randomized mix of modes, bouncy key, halt requests and period writes.
    mode_sel = 2'b00; repeat (4) tick();
    key_tgt = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) mode_sel = 2'($urandom_range(0, 3));
      halt_req = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 29) == 0) begin
        tmin_wr = 1'b1; tmin_data = 32'($urandom_range(0, 6));
      end else tmin_wr = 1'b0;
      if ($urandom_range(0, 59) == 0) key_tgt = ~key_tgt;
      step_key = ($urandom_range(0, 7) == 0) ? ~key_tgt : key_tgt;
      tick();
    end
    halt_req = 1'b0; tmin_wr = 1'b0; step_key = 1'b1;

    // Asynchronous reset between edges while pulsing every cycle.
    mode_sel = 2'b00; repeat (4) tick();
    mode_sel = 2'b11; repeat (10) tick();
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_cpu_en", {63'd0, cpu_en}, 64'd0);
    check_val("arst_c0", {63'd0, c0}, 64'd0);
    check_val("arst_state", {62'd0, state}, 64'd0);
    check_val("arst_cycle_cnt", {32'd0, cycle_cnt}, 64'd0);
    model_reset();
    tick();
    rst_n = 1'b1; mode_sel = 2'b01;
    repeat (60) tick();
    check_val("recover_run", {62'd0, state}, 64'd1);
    check_val("recover_cnt", {32'd0, cycle_cnt}, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
